// File: rtl/ad9361_tdd_pkg.sv
// Shared definitions for the AD9361 TDD arbiter: FSM state encoding and
// direction constants.
package ad9361_tdd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACTIVE = 3'd2,
    HOLD   = 3'd3
  } tdd_state_t;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

endpackage

// File: rtl/ad9361_tdd_timer.sv
// Loadable down-counter that saturates at zero; used for phase and dwell timing.
module ad9361_tdd_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 dec,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ad9361_tdd_arbiter.sv
// Arbitrates the AD9361 between RX and TX requesters in TDD mode, sequencing
// TXNRX setup, ENABLE, and the post-ENABLE guard interval.
module ad9361_tdd_arbiter
  import ad9361_tdd_pkg::*;
#(
  parameter int SETUP_CYCLES = 4,
  parameter int GUARD_CYCLES = 8,
  parameter int MAX_DWELL    = 1024,
  parameter int CNT_WIDTH    = 16
) (
  input  logic       axi_aclk,
  input  logic       axi_areset,
  input  logic       rx_req,
  input  logic       tx_req,
  output logic       rx_gnt,
  output logic       tx_gnt,
  output logic       up_enable,
  output logic       up_txnrx,
  output logic       busy,
  output logic       preempt,
  output logic [2:0] state
);

  localparam logic [CNT_WIDTH-1:0] SETUP_LOAD = CNT_WIDTH'(SETUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GUARD_LOAD = CNT_WIDTH'(GUARD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DWELL_LOAD = (MAX_DWELL == 0) ? '0 : CNT_WIDTH'(MAX_DWELL - 1);
  localparam logic                 DWELL_EN   = (MAX_DWELL != 0);

  tdd_state_t           state_q, state_n;
  logic                 dir_q, dir_n;
  logic                 last_q, last_n;
  logic                 preempt_n;
  logic                 ph_load, dw_load, ph_zero, dw_zero;
  logic [CNT_WIDTH-1:0] ph_val;
  logic                 owner_req, other_req;

  // Requests and grants are levels: a requester holds req high for as long as
  // it wants the radio; gnt rises only once TXNRX has settled and ENABLE is
  // driven, and falls on the edge after req drops or on a dwell preemption.
  assign owner_req = (dir_q == DIR_TX) ? tx_req : rx_req;
  assign other_req = (dir_q == DIR_TX) ? rx_req : tx_req;

  ad9361_tdd_timer #(.CNT_WIDTH(CNT_WIDTH)) u_phase_timer (
    .clk      (axi_aclk),
    .rst      (axi_areset),
    .load     (ph_load),
    .dec      (1'b1),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

  ad9361_tdd_timer #(.CNT_WIDTH(CNT_WIDTH)) u_dwell_timer (
    .clk      (axi_aclk),
    .rst      (axi_areset),
    .load     (dw_load),
    .dec      (state_q == ACTIVE),
    .load_val (DWELL_LOAD),
    .zero     (dw_zero)
  );

  always_comb begin
    state_n   = state_q;
    dir_n     = dir_q;
    last_n    = last_q;
    preempt_n = 1'b0;
    ph_load   = 1'b0;
    ph_val    = '0;
    dw_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_req || tx_req) begin
          // Round-robin on contention: the side not granted last time wins.
          dir_n   = (rx_req && tx_req) ? ~last_q : tx_req;
          state_n = SETUP;
          ph_load = 1'b1;
          ph_val  = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (!owner_req) begin
          state_n = HOLD;
          ph_load = 1'b1;
          ph_val  = GUARD_LOAD;
        end else if (ph_zero) begin
          state_n = ACTIVE;
          last_n  = dir_q;
          dw_load = 1'b1;
        end
      end
      ACTIVE: begin
        if (!owner_req) begin
          state_n = HOLD;
          ph_load = 1'b1;
          ph_val  = GUARD_LOAD;
        end else if (DWELL_EN && dw_zero) begin
          if (other_req) begin
            state_n   = HOLD;
            preempt_n = 1'b1;
            ph_load   = 1'b1;
            ph_val    = GUARD_LOAD;
          end else begin
            dw_load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (ph_zero) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_RX;
      last_q    <= DIR_TX;
      rx_gnt    <= 1'b0;
      tx_gnt    <= 1'b0;
      up_enable <= 1'b0;
      up_txnrx  <= 1'b0;
      busy      <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state_q   <= state_n;
      dir_q     <= dir_n;
      last_q    <= last_n;
      rx_gnt    <= (state_n == ACTIVE) && (dir_n == DIR_RX);
      tx_gnt    <= (state_n == ACTIVE) && (dir_n == DIR_TX);
      up_enable <= (state_n == ACTIVE);
      // TXNRX follows dir through SETUP/ACTIVE/HOLD so it never moves under ENABLE.
      up_txnrx  <= (state_n != IDLE) ? dir_n : 1'b0;
      busy      <= (state_n != IDLE);
      preempt   <= preempt_n;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ad9361_tdd_arbiter.sv
// Scoreboard bench for ad9361_tdd_arbiter: every output change is matched
// against a hand-computed expected event (cycle stamp plus output vector).
module tb_ad9361_tdd_arbiter;

  logic       axi_aclk = 1'b0;
  logic       axi_areset;
  logic       rx_req, tx_req;
  logic       rx_gnt, tx_gnt, up_enable, up_txnrx, busy, preempt;
  logic [2:0] state;

  int cyc = 0;
  int b   = 0;
  int n_checks = 0;
  int n_fails  = 0;
  bit mon_en   = 1'b0;

  logic [40:0] exp_q[$];
  logic [8:0]  prev_v;

  ad9361_tdd_arbiter #(
    .SETUP_CYCLES (4),
    .GUARD_CYCLES (8),
    .MAX_DWELL    (16),
    .CNT_WIDTH    (16)
  ) dut (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .rx_req     (rx_req),
    .tx_req     (tx_req),
    .rx_gnt     (rx_gnt),
    .tx_gnt     (tx_gnt),
    .up_enable  (up_enable),
    .up_txnrx   (up_txnrx),
    .busy       (busy),
    .preempt    (preempt),
    .state      (state)
  );

  // clock / cycle counter
  always #5 axi_aclk = ~axi_aclk;
  always @(posedge axi_aclk) cyc <= cyc + 1;

  function automatic logic [8:0] ov(input logic [2:0] st, input logic en, input logic txnrx,
                                    input logic rg, input logic tg, input logic bz, input logic pr);
    return {st, en, txnrx, rg, tg, bz, pr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic exp_ev(input int dc, input logic [8:0] v);
    exp_q.push_back({32'(b + dc), v});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge axi_aclk);
      #1;
    end
  endtask

  task automatic start_scenario();
    @(posedge axi_aclk);
    #1;
    b = cyc;
  endtask

  task automatic do_reset();
    @(posedge axi_aclk);
    #1;
    axi_areset = 1'b1;
    step(2);
    axi_areset = 1'b0;
    step(1);
  endtask

  // monitor: pops one expected event per observed output change
  always @(negedge axi_aclk) begin
    logic [8:0]  cur;
    logic [40:0] e;
    if (mon_en) begin
      cur = {state, up_enable, up_txnrx, rx_gnt, tx_gnt, busy, preempt};
      chk("gnt_overlap", 32'(rx_gnt & tx_gnt), 32'd0);
      if (prev_v[5] && up_enable) chk("txnrx_stable_under_enable", 32'(up_txnrx), 32'(prev_v[4]));
      if (cur !== prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_change", 32'(cur), 32'(prev_v));
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", 32'(cyc), e[40:9]);
          chk("event_outputs", 32'(cur), 32'(e[8:0]));
        end
      end
      prev_v = cur;
    end
  end

  initial begin
    axi_areset = 1'b1;
    rx_req = 1'b0;
    tx_req = 1'b0;
    prev_v = '0;
    step(3);
    chk("reset_outputs", 32'({state, up_enable, up_txnrx, rx_gnt, tx_gnt, busy, preempt}), 32'd0);
    axi_areset = 1'b0;
    mon_en = 1'b1;
    step(2);

    // A: single RX transaction
    start_scenario();
    exp_ev(1,  ov(3'd1, 0, 0, 0, 0, 1, 0));
    exp_ev(5,  ov(3'd2, 1, 0, 1, 0, 1, 0));
    exp_ev(21, ov(3'd3, 0, 0, 0, 0, 1, 0));
    exp_ev(29, ov(3'd0, 0, 0, 0, 0, 0, 0));
    rx_req = 1'b1;
    step(20);
    rx_req = 1'b0;
    step(12);

    // B: simultaneous requests after reset, RX first then TX after guard + setup
    do_reset();
    start_scenario();
    exp_ev(1,  ov(3'd1, 0, 0, 0, 0, 1, 0));
    exp_ev(5,  ov(3'd2, 1, 0, 1, 0, 1, 0));
    exp_ev(11, ov(3'd3, 0, 0, 0, 0, 1, 0));
    exp_ev(19, ov(3'd0, 0, 0, 0, 0, 0, 0));
    exp_ev(20, ov(3'd1, 0, 1, 0, 0, 1, 0));
    exp_ev(24, ov(3'd2, 1, 1, 0, 1, 1, 0));
    exp_ev(31, ov(3'd3, 0, 1, 0, 0, 1, 0));
    exp_ev(39, ov(3'd0, 0, 0, 0, 0, 0, 0));
    rx_req = 1'b1;
    tx_req = 1'b1;
    step(10);
    rx_req = 1'b0;
    step(20);
    tx_req = 1'b0;
    step(12);

    // C: both held, dwell preemption alternates RX, TX, RX
    do_reset();
    start_scenario();
    exp_ev(1,  ov(3'd1, 0, 0, 0, 0, 1, 0));
    exp_ev(5,  ov(3'd2, 1, 0, 1, 0, 1, 0));
    exp_ev(21, ov(3'd3, 0, 0, 0, 0, 1, 1));
    exp_ev(22, ov(3'd3, 0, 0, 0, 0, 1, 0));
    exp_ev(29, ov(3'd0, 0, 0, 0, 0, 0, 0));
    exp_ev(30, ov(3'd1, 0, 1, 0, 0, 1, 0));
    exp_ev(34, ov(3'd2, 1, 1, 0, 1, 1, 0));
    exp_ev(50, ov(3'd3, 0, 1, 0, 0, 1, 1));
    exp_ev(51, ov(3'd3, 0, 1, 0, 0, 1, 0));
    exp_ev(58, ov(3'd0, 0, 0, 0, 0, 0, 0));
    exp_ev(59, ov(3'd1, 0, 0, 0, 0, 1, 0));
    exp_ev(63, ov(3'd2, 1, 0, 1, 0, 1, 0));
    exp_ev(71, ov(3'd3, 0, 0, 0, 0, 1, 0));
    exp_ev(79, ov(3'd0, 0, 0, 0, 0, 0, 0));
    rx_req = 1'b1;
    tx_req = 1'b1;
    step(70);
    rx_req = 1'b0;
    tx_req = 1'b0;
    step(12);

    // D: TX alone for 100 cycles, dwell limit must not release
    start_scenario();
    exp_ev(1,   ov(3'd1, 0, 1, 0, 0, 1, 0));
    exp_ev(5,   ov(3'd2, 1, 1, 0, 1, 1, 0));
    exp_ev(101, ov(3'd3, 0, 1, 0, 0, 1, 0));
    exp_ev(109, ov(3'd0, 0, 0, 0, 0, 0, 0));
    tx_req = 1'b1;
    step(100);
    tx_req = 1'b0;
    step(12);

    // E: TX request withdrawn during SETUP
    start_scenario();
    exp_ev(1,  ov(3'd1, 0, 1, 0, 0, 1, 0));
    exp_ev(3,  ov(3'd3, 0, 1, 0, 0, 1, 0));
    exp_ev(11, ov(3'd0, 0, 0, 0, 0, 0, 0));
    tx_req = 1'b1;
    step(2);
    tx_req = 1'b0;
    step(12);

    // F: asynchronous reset mid-ACTIVE, then normal sequence
    start_scenario();
    exp_ev(1,  ov(3'd1, 0, 0, 0, 0, 1, 0));
    exp_ev(5,  ov(3'd2, 1, 0, 1, 0, 1, 0));
    exp_ev(8,  ov(3'd0, 0, 0, 0, 0, 0, 0));
    exp_ev(11, ov(3'd1, 0, 0, 0, 0, 1, 0));
    exp_ev(15, ov(3'd2, 1, 0, 1, 0, 1, 0));
    exp_ev(21, ov(3'd3, 0, 0, 0, 0, 1, 0));
    exp_ev(29, ov(3'd0, 0, 0, 0, 0, 0, 0));
    rx_req = 1'b1;
    step(8);
    #2;
    axi_areset = 1'b1;
    #1;
    chk("async_reset_enable", 32'(up_enable), 32'd0);
    chk("async_reset_rx_gnt", 32'(rx_gnt), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    step(2);
    axi_areset = 1'b0;
    step(10);
    rx_req = 1'b0;
    step(12);

    chk("pending_events", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
